// File: rtl/mips_wb_pkg.sv
// Shared encodings for the write-back stage: result-source select codes
// and the multiply scoreboard state.
package mips_wb_pkg;

  localparam logic [1:0] OUT_ALU = 2'b00;
  localparam logic [1:0] OUT_LO  = 2'b01;
  localparam logic [1:0] OUT_HI  = 2'b10;
  localparam logic [1:0] OUT_LUI = 2'b11;

  typedef enum logic [1:0] {
    SB_IDLE = 2'd0,
    SB_BUSY = 2'd1,
    SB_FULL = 2'd2
  } sb_state_e;

endpackage

// File: rtl/writeback_hilo_if.sv
// Bundle of M/W pipeline-register outputs, decode-side hazard signals and
// write-back results.
// Flow control: there is no valid/ready pair. The W-stage contents are
// consumed on a rising edge exactly when nEN==0; while nEN==1 the stage is
// frozen and nothing commits. Combinational outputs are valid every cycle.
// dbg_count / dbg_state expose the scoreboard for observation only.
interface writeback_hilo_if
  import mips_wb_pkg::*;
#(
  parameter int CNT_W = 2
);
  logic              nEN;
  logic              RegWriteW;
  logic              MemtoRegW;
  logic              mult_finishW;
  logic [1:0]        Out_SelectW;
  logic [31:0]       ALUoutW;
  logic [63:0]       mult_resultW;
  logic [31:0]       ReadDataW;
  logic [31:0]       lui_extendedW;
  logic [4:0]        WriteRegW;
  logic              mult_startD;
  logic              hilo_readD;

  logic              RegWriteEnW;
  logic [4:0]        WriteAddrW;
  logic [31:0]       ResultW;
  logic [31:0]       HI;
  logic [31:0]       LO;
  logic              StallHiLoD;
  logic              pend_err;
  logic [CNT_W-1:0]  dbg_count;
  sb_state_e         dbg_state;

  modport master (
    output nEN, RegWriteW, MemtoRegW, mult_finishW, Out_SelectW, ALUoutW,
           mult_resultW, ReadDataW, lui_extendedW, WriteRegW, mult_startD,
           hilo_readD,
    input  RegWriteEnW, WriteAddrW, ResultW, HI, LO, StallHiLoD, pend_err,
           dbg_count, dbg_state
  );

  modport slave (
    input  nEN, RegWriteW, MemtoRegW, mult_finishW, Out_SelectW, ALUoutW,
           mult_resultW, ReadDataW, lui_extendedW, WriteRegW, mult_startD,
           hilo_readD,
    output RegWriteEnW, WriteAddrW, ResultW, HI, LO, StallHiLoD, pend_err,
           dbg_count, dbg_state
  );
endinterface

// File: rtl/hilo_scoreboard.sv
// Tracks multiplies in flight between decode and write-back, stalls decode
// when an mfhi/mflo would read stale HI/LO or the tracker is full, and
// latches a sticky error on underflow/overflow.
// Optional feature macro: WB_HILO_BYPASS_EN (releases the stall in the
// cycle of the final decrement, since W then forwards the fresh product).
module hilo_scoreboard
  import mips_wb_pkg::*;
#(
  parameter int MAX_PEND = 3,
  parameter int CNT_W    = $clog2(MAX_PEND + 1)
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             mult_start_i,
  input  logic             hilo_read_i,
  input  logic             dec_i,
  output logic             stall_o,
  output logic             pend_err_o,
  output logic [CNT_W-1:0] count_o,
  output sb_state_e        state_o
);

  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(MAX_PEND);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_ZERO = '0;

  logic [CNT_W-1:0] count_q, count_d;
  sb_state_e        state_q, state_d;
  logic             err_q, err_d;
  logic             stall;
  logic             inc;

  // A start only counts once decode is actually allowed to issue it.
  assign inc = mult_start_i & ~stall;

  // State register: counter, scoreboard state and sticky error.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      count_q <= CNT_ZERO;
      state_q <= SB_IDLE;
      err_q   <= 1'b0;
    end else begin
      count_q <= count_d;
      state_q <= state_d;
      err_q   <= err_d;
    end
  end

  // Next state: saturating up/down count; simultaneous inc and dec cancel.
  always_comb begin
    count_d = count_q;
    err_d   = err_q;
    if (inc && !dec_i) begin
      if (count_q != CNT_MAX) count_d = count_q + CNT_ONE;
      else                    err_d   = 1'b1;
    end else if (dec_i && !inc) begin
      if (count_q != CNT_ZERO) count_d = count_q - CNT_ONE;
    end
    if (dec_i && count_q == CNT_ZERO) err_d = 1'b1;
    if (count_d == CNT_ZERO)     state_d = SB_IDLE;
    else if (count_d == CNT_MAX) state_d = SB_FULL;
    else                         state_d = SB_BUSY;
  end

  // Outputs: decode stall from the registered state.
  always_comb begin
    stall = mult_start_i & (state_q == SB_FULL);
`ifdef WB_HILO_BYPASS_EN
    if (hilo_read_i && state_q != SB_IDLE &&
        !(count_q == CNT_ONE && dec_i)) stall = 1'b1;
`else
    if (hilo_read_i && state_q != SB_IDLE) stall = 1'b1;
`endif
  end

  assign stall_o    = stall;
  assign pend_err_o = err_q;
  assign count_o    = count_q;
  assign state_o    = state_q;

endmodule

// File: rtl/writeback_hilo.sv
// Write-back stage: selects register-file write data, owns HI/LO and commits
// multiply products into them; scoreboard lives in hilo_scoreboard.
// Optional feature macro: WB_HILO_BYPASS_EN (mfhi/mflo in W sees the product
// committing in the same cycle).
module writeback_hilo
  import mips_wb_pkg::*;
#(
  parameter int MAX_PEND = 3,
  parameter int CNT_W    = $clog2(MAX_PEND + 1)
) (
  input  logic             CLK,
  input  logic             reset,
  writeback_hilo_if.slave  wb
);

  logic        commit;
  logic        dec;
  logic [31:0] hi_q, hi_d;
  logic [31:0] lo_q, lo_d;
  logic [31:0] result;

  assign commit = ~wb.nEN;
  assign dec    = commit & wb.mult_finishW;

  // HI/LO next value: load the product only when a finished multiply commits.
  always_comb begin
    hi_d = hi_q;
    lo_d = lo_q;
    if (dec) begin
      hi_d = wb.mult_resultW[63:32];
      lo_d = wb.mult_resultW[31:0];
    end
  end

  // HI/LO architectural registers.
  always_ff @(posedge CLK) begin
    if (reset) begin
      hi_q <= 32'd0;
      lo_q <= 32'd0;
    end else begin
      hi_q <= hi_d;
      lo_q <= lo_d;
    end
  end

  // Result mux: ALU/mem, LO, HI or the pre-shifted LUI immediate.
  always_comb begin
    result = wb.ALUoutW;
    case (wb.Out_SelectW)
      OUT_ALU: result = wb.MemtoRegW ? wb.ReadDataW : wb.ALUoutW;
`ifdef WB_HILO_BYPASS_EN
      OUT_LO:  result = wb.mult_finishW ? wb.mult_resultW[31:0]  : lo_q;
      OUT_HI:  result = wb.mult_finishW ? wb.mult_resultW[63:32] : hi_q;
`else
      OUT_LO:  result = lo_q;
      OUT_HI:  result = hi_q;
`endif
      OUT_LUI: result = wb.lui_extendedW;
      default: result = wb.ALUoutW;
    endcase
  end

  assign wb.ResultW     = result;
  assign wb.RegWriteEnW = wb.RegWriteW & commit;
  assign wb.WriteAddrW  = wb.WriteRegW;
  assign wb.HI          = hi_q;
  assign wb.LO          = lo_q;

  hilo_scoreboard #(
    .MAX_PEND (MAX_PEND),
    .CNT_W    (CNT_W)
  ) u_sb (
    .clk_i        (CLK),
    .rst_i        (reset),
    .mult_start_i (wb.mult_startD),
    .hilo_read_i  (wb.hilo_readD),
    .dec_i        (dec),
    .stall_o      (wb.StallHiLoD),
    .pend_err_o   (wb.pend_err),
    .count_o      (wb.dbg_count),
    .state_o      (wb.dbg_state)
  );

endmodule

// File: tb/tb_writeback_hilo.sv
module tb_writeback_hilo;
  import mips_wb_pkg::*;

  localparam int MAX_PEND = 3;
  localparam int CNT_W    = 2;

  // ---------------- clock / reset ----------------
  logic CLK = 1'b0;
  logic reset;
  always #5 CLK = ~CLK;

  writeback_hilo_if #(.CNT_W(CNT_W)) wb ();

  writeback_hilo #(.MAX_PEND(MAX_PEND), .CNT_W(CNT_W)) dut (
    .CLK   (CLK),
    .reset (reset),
    .wb    (wb.slave)
  );

  // ---------------- reference model ----------------
  int          errors = 0;
  int          checks = 0;
  int          m_count;
  bit          m_err;
  logic [31:0] m_hi, m_lo;
  logic [63:0] exp_q[$];   // products of multiplies still in flight

  function automatic bit exp_stall();
    bit dec;
    dec = !wb.nEN && wb.mult_finishW;
`ifdef WB_HILO_BYPASS_EN
    return (wb.hilo_readD && m_count > 0 && !(m_count == 1 && dec)) ||
           (wb.mult_startD && m_count == MAX_PEND);
`else
    return (wb.hilo_readD && m_count > 0) ||
           (wb.mult_startD && m_count == MAX_PEND);
`endif
  endfunction

  function automatic logic [31:0] exp_result();
    logic [31:0] lo_v, hi_v;
    lo_v = m_lo;
    hi_v = m_hi;
`ifdef WB_HILO_BYPASS_EN
    if (wb.mult_finishW) begin
      lo_v = wb.mult_resultW[31:0];
      hi_v = wb.mult_resultW[63:32];
    end
`endif
    case (wb.Out_SelectW)
      2'd0:    return wb.MemtoRegW ? wb.ReadDataW : wb.ALUoutW;
      2'd1:    return lo_v;
      2'd2:    return hi_v;
      default: return wb.lui_extendedW;
    endcase
  endfunction

  // ---------------- driver tasks ----------------
  task automatic set_idle();
    wb.nEN = 1'b0; wb.RegWriteW = 1'b0; wb.MemtoRegW = 1'b0;
    wb.mult_finishW = 1'b0; wb.Out_SelectW = 2'd0; wb.ALUoutW = '0;
    wb.mult_resultW = '0; wb.ReadDataW = '0; wb.lui_extendedW = '0;
    wb.WriteRegW = '0; wb.mult_startD = 1'b0; wb.hilo_readD = 1'b0;
  endtask

  // One clock: advance the model with the inputs held across the edge,
  // then return at the following falling edge so the caller can drive.
  task automatic tick();
    bit dec, inc;
    dec = !wb.nEN && wb.mult_finishW;
    inc = wb.mult_startD && !exp_stall();
    @(posedge CLK);
    if (reset) begin
      m_count = 0; m_err = 0; m_hi = '0; m_lo = '0;
    end else begin
      if (dec && m_count == 0) m_err = 1;
      if (inc && !dec) begin
        if (m_count < MAX_PEND) m_count++;
        else m_err = 1;
      end else if (dec && !inc && m_count > 0) begin
        m_count--;
      end
      if (dec) {m_hi, m_lo} = wb.mult_resultW;
    end
    @(negedge CLK);
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    set_idle();
    reset = 1'b1;
    repeat (2) tick();
    reset = 1'b0;
    #1;
    checks++; if (wb.HI !== 32'd0) begin errors++; $display("FAIL reset_hi: got %h want 0", wb.HI); end
    checks++; if (wb.LO !== 32'd0) begin errors++; $display("FAIL reset_lo: got %h want 0", wb.LO); end
    checks++; if (wb.StallHiLoD !== 1'b0) begin errors++; $display("FAIL reset_stall: got %b want 0", wb.StallHiLoD); end
    checks++; if (wb.pend_err !== 1'b0) begin errors++; $display("FAIL reset_err: got %b want 0", wb.pend_err); end
    checks++; if (wb.dbg_state !== SB_IDLE) begin errors++; $display("FAIL reset_state: got %0d want IDLE", wb.dbg_state); end
    wb.ALUoutW = 32'h1234; wb.RegWriteW = 1'b1; wb.WriteRegW = 5'd9;
    #1;
    checks++; if (wb.ResultW !== 32'h1234) begin errors++; $display("FAIL alu_result: got %h want 00001234", wb.ResultW); end
    checks++; if (wb.RegWriteEnW !== 1'b1) begin errors++; $display("FAIL alu_we: got %b want 1", wb.RegWriteEnW); end
    checks++; if (wb.WriteAddrW !== 5'd9) begin errors++; $display("FAIL alu_addr: got %0d want 9", wb.WriteAddrW); end
    tick();
  endtask

  task automatic test_mult_commit();
    set_idle();
    wb.mult_startD = 1'b1;
    tick();
    wb.mult_startD = 1'b0;
    #1;
    checks++; if (wb.dbg_count !== 2'd1) begin errors++; $display("FAIL mc_count: got %0d want 1", wb.dbg_count); end
    checks++; if (wb.dbg_state !== SB_BUSY) begin errors++; $display("FAIL mc_state: got %0d want BUSY", wb.dbg_state); end
    repeat (3) tick();
    wb.mult_finishW = 1'b1;
    wb.mult_resultW = 64'hDEADBEEF_00000007;
    #1;
    checks++; if (wb.HI !== 32'd0) begin errors++; $display("FAIL mc_hi_before: got %h want 0", wb.HI); end
    tick();
    set_idle();
    #1;
    checks++; if (wb.HI !== 32'hDEADBEEF) begin errors++; $display("FAIL mc_hi: got %h want deadbeef", wb.HI); end
    checks++; if (wb.LO !== 32'd7) begin errors++; $display("FAIL mc_lo: got %h want 7", wb.LO); end
    checks++; if (wb.dbg_count !== 2'd0) begin errors++; $display("FAIL mc_count_after: got %0d want 0", wb.dbg_count); end
    wb.Out_SelectW = 2'd2;
    #1;
    checks++; if (wb.ResultW !== 32'hDEADBEEF) begin errors++; $display("FAIL mfhi: got %h want deadbeef", wb.ResultW); end
    wb.Out_SelectW = 2'd1;
    #1;
    checks++; if (wb.ResultW !== 32'd7) begin errors++; $display("FAIL mflo: got %h want 7", wb.ResultW); end
    tick();
  endtask

  task automatic test_stall();
    logic        exp_s;
    logic [31:0] exp_r;
    set_idle();
    wb.mult_startD = 1'b1;
    tick();
    wb.mult_startD = 1'b0;
    wb.hilo_readD = 1'b1;
    for (int i = 0; i < 2; i++) begin
      #1;
      checks++; if (wb.StallHiLoD !== 1'b1) begin errors++; $display("FAIL stall_wait%0d: got %b want 1", i, wb.StallHiLoD); end
      tick();
    end
    wb.mult_finishW = 1'b1;
    wb.mult_resultW = 64'h11111111_22222222;
    wb.Out_SelectW = 2'd2;
`ifdef WB_HILO_BYPASS_EN
    exp_s = 1'b0; exp_r = 32'h11111111;
`else
    exp_s = 1'b1; exp_r = 32'hDEADBEEF;
`endif
    #1;
    checks++; if (wb.StallHiLoD !== exp_s) begin errors++; $display("FAIL stall_dec_cycle: got %b want %b", wb.StallHiLoD, exp_s); end
    checks++; if (wb.ResultW !== exp_r) begin errors++; $display("FAIL mfhi_same_cycle: got %h want %h", wb.ResultW, exp_r); end
    tick();
    wb.mult_finishW = 1'b0;
    #1;
    checks++; if (wb.StallHiLoD !== 1'b0) begin errors++; $display("FAIL stall_release: got %b want 0", wb.StallHiLoD); end
    checks++; if (wb.ResultW !== 32'h11111111) begin errors++; $display("FAIL mfhi_after: got %h want 11111111", wb.ResultW); end
    tick();
  endtask

  task automatic test_frozen();
    set_idle();
    wb.mult_startD = 1'b1;
    tick();
    set_idle();
    wb.nEN = 1'b1; wb.mult_finishW = 1'b1; wb.RegWriteW = 1'b1;
    wb.mult_resultW = 64'hCAFEF00D_0BADF00D;
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++; if (wb.RegWriteEnW !== 1'b0) begin errors++; $display("FAIL frz_we%0d: got %b want 0", i, wb.RegWriteEnW); end
      checks++; if (wb.dbg_count !== 2'd1) begin errors++; $display("FAIL frz_count%0d: got %0d want 1", i, wb.dbg_count); end
      checks++; if (wb.HI !== 32'h11111111) begin errors++; $display("FAIL frz_hi%0d: got %h want 11111111", i, wb.HI); end
      tick();
    end
    wb.nEN = 1'b0;
    #1;
    checks++; if (wb.RegWriteEnW !== 1'b1) begin errors++; $display("FAIL frz_release_we: got %b want 1", wb.RegWriteEnW); end
    tick();
    set_idle();
    #1;
    checks++; if (wb.dbg_count !== 2'd0) begin errors++; $display("FAIL frz_count_after: got %0d want 0", wb.dbg_count); end
    checks++; if (wb.HI !== 32'hCAFEF00D) begin errors++; $display("FAIL frz_hi_after: got %h want cafef00d", wb.HI); end
    checks++; if (wb.LO !== 32'h0BADF00D) begin errors++; $display("FAIL frz_lo_after: got %h want 0badf00d", wb.LO); end
    checks++; if (wb.pend_err !== 1'b0) begin errors++; $display("FAIL frz_err: got %b want 0", wb.pend_err); end
  endtask

  task automatic test_saturation();
    set_idle();
    wb.mult_startD = 1'b1;
    repeat (3) tick();
    #1;
    checks++; if (wb.dbg_count !== 2'd3) begin errors++; $display("FAIL sat_count: got %0d want 3", wb.dbg_count); end
    checks++; if (wb.dbg_state !== SB_FULL) begin errors++; $display("FAIL sat_state: got %0d want FULL", wb.dbg_state); end
    checks++; if (wb.StallHiLoD !== 1'b1) begin errors++; $display("FAIL sat_stall: got %b want 1", wb.StallHiLoD); end
    tick();
    #1;
    checks++; if (wb.dbg_count !== 2'd3) begin errors++; $display("FAIL sat_count_hold: got %0d want 3", wb.dbg_count); end
    checks++; if (wb.pend_err !== 1'b0) begin errors++; $display("FAIL sat_err: got %b want 0", wb.pend_err); end
    set_idle();
    wb.mult_finishW = 1'b1;
    for (int i = 0; i < 3; i++) begin
      wb.mult_resultW = {$urandom, $urandom};
      tick();
    end
    set_idle();
    #1;
    checks++; if (wb.dbg_count !== 2'd0) begin errors++; $display("FAIL sat_drain: got %0d want 0", wb.dbg_count); end
    checks++; if (wb.HI !== m_hi) begin errors++; $display("FAIL sat_hi: got %h want %h", wb.HI, m_hi); end
  endtask

  task automatic test_underflow();
    set_idle();
    wb.mult_finishW = 1'b1;
    wb.mult_resultW = {$urandom, $urandom};
    #1;
    checks++; if (wb.pend_err !== 1'b0) begin errors++; $display("FAIL uf_before: got %b want 0", wb.pend_err); end
    tick();
    wb.mult_finishW = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++; if (wb.pend_err !== 1'b1) begin errors++; $display("FAIL uf_sticky%0d: got %b want 1", i, wb.pend_err); end
      tick();
    end
    reset = 1'b1;
    tick();
    reset = 1'b0;
    #1;
    checks++; if (wb.pend_err !== 1'b0) begin errors++; $display("FAIL uf_cleared: got %b want 0", wb.pend_err); end
    checks++; if (wb.HI !== 32'd0) begin errors++; $display("FAIL uf_reset_hi: got %h want 0", wb.HI); end
  endtask

  task automatic test_random();
    bit          dec, inc;
    logic [31:0] exp_r;
    exp_q.delete();
    for (int n = 0; n < 400; n++) begin
      wb.nEN          = ($urandom_range(0, 3) == 0);
      wb.mult_startD  = ($urandom_range(0, 2) == 0);
      wb.hilo_readD   = ($urandom_range(0, 3) == 0);
      wb.RegWriteW    = $urandom_range(0, 1);
      wb.MemtoRegW    = $urandom_range(0, 1);
      wb.Out_SelectW  = 2'($urandom_range(0, 3));
      wb.ALUoutW      = $urandom;
      wb.ReadDataW    = $urandom;
      wb.lui_extendedW = $urandom;
      wb.WriteRegW    = 5'($urandom_range(0, 31));
      if (exp_q.size() > 0) begin
        wb.mult_finishW = ($urandom_range(0, 2) == 0);
        wb.mult_resultW = exp_q[0];
      end else begin
        wb.mult_finishW = ($urandom_range(0, 30) == 0);
        wb.mult_resultW = {$urandom, $urandom};
      end
      reset = ($urandom_range(0, 60) == 0);
      #1;
      exp_r = exp_result();
      checks++; if (wb.ResultW !== exp_r) begin errors++; $display("FAIL rnd_result@%0d: got %h want %h", n, wb.ResultW, exp_r); end
      checks++; if (wb.RegWriteEnW !== (wb.RegWriteW && !wb.nEN)) begin errors++; $display("FAIL rnd_we@%0d: got %b", n, wb.RegWriteEnW); end
      checks++; if (wb.WriteAddrW !== wb.WriteRegW) begin errors++; $display("FAIL rnd_addr@%0d: got %0d want %0d", n, wb.WriteAddrW, wb.WriteRegW); end
      checks++; if (wb.StallHiLoD !== exp_stall()) begin errors++; $display("FAIL rnd_stall@%0d: got %b want %b", n, wb.StallHiLoD, exp_stall()); end
      checks++; if (wb.HI !== m_hi || wb.LO !== m_lo) begin errors++; $display("FAIL rnd_hilo@%0d: got %h_%h want %h_%h", n, wb.HI, wb.LO, m_hi, m_lo); end
      checks++; if (wb.dbg_count !== 2'(m_count)) begin errors++; $display("FAIL rnd_count@%0d: got %0d want %0d", n, wb.dbg_count, m_count); end
      checks++; if (wb.pend_err !== m_err) begin errors++; $display("FAIL rnd_err@%0d: got %b want %b", n, wb.pend_err, m_err); end
      dec = !wb.nEN && wb.mult_finishW;
      inc = wb.mult_startD && !exp_stall();
      tick();
      if (reset) exp_q.delete();
      else begin
        if (dec && exp_q.size() > 0) void'(exp_q.pop_front());
        if (inc) exp_q.push_back({$urandom, $urandom});
      end
    end
    reset = 1'b0;
    set_idle();
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    m_count = 0; m_err = 0; m_hi = '0; m_lo = '0;
    reset = 1'b1;
    set_idle();
    test_reset();
    test_mult_commit();
    test_stall();
    test_frozen();
    test_saturation();
    test_underflow();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
